if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction fetch initiator for the ARM pipeline; drives the word address into the combinational instruction memory and captures the returned instruction word.
- Buffers fetched words with their PC+4 in a small prefetch FIFO and presents them to the IF/ID boundary through a valid/ready handshake.
- Accepts branch redirects from EX, which flush the FIFO and restart fetch at the target.

Parameters:
- FIFO_DEPTH, 4, number of prefetch entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000, fetch address after reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- inst_addr  output  32  byte address to instruction memory; equals fetch_pc; bits [1:0] are always 0.
- inst_data  input  32  instruction word returned combinationally for inst_addr in the same cycle.
- out_valid  output  1  FIFO head holds a valid instruction.
- out_ready  input  1  ID stage accepts the head this cycle (the inverse of freeze).
- out_inst  output  32  head instruction word.
- out_pc  output  32  head instruction address + 4.
- branch_taken  input  1  redirect request from EX.
- branch_addr  input  32  redirect target byte address.
- fetch_count  output  32  present only with FETCH_STATS_EN.
- flush_count  output  32  present only with FETCH_STATS_EN.

Behaviour:
- State: fetch_pc (32), FIFO storage of FIFO_DEPTH x {inst, pc+4}, rd_ptr, wr_ptr, count (0..FIFO_DEPTH).
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - fetch_pc = RESET_PC.
  - Pointers and count = 0.
  - out_valid = 0; out_inst and out_pc = 0; statistics counters = 0.
- out_valid = (count != 0). When count = 0, out_inst and out_pc are forced to 0; otherwise they show the head entry combinationally.
- pop = out_valid & out_ready & ~branch_taken.
- push = ~branch_taken & ((count < FIFO_DEPTH) | pop). A full FIFO that is popped in the same cycle still accepts a push.
- On push:
  - Write {inst_data, fetch_pc + 4} at wr_ptr.
  - wr_ptr advances, wrapping modulo FIFO_DEPTH.
  - fetch_pc <= fetch_pc + 4, wrapping modulo 2^32 (0xFFFF_FFFC goes to 0).
- On pop: rd_ptr advances, wrapping modulo FIFO_DEPTH.
- count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop.
- When the FIFO is full with no pop: no push; fetch_pc and inst_addr hold.
- Branch (branch_taken = 1 at a clock edge) has priority over push and pop:
  - count, rd_ptr and wr_ptr <= 0, so all entries are discarded, including the head even if out_ready = 1.
  - fetch_pc <= {branch_addr[31:2], 2'b00}.
  - No word is captured that cycle.
- Latency:
  - First valid output in the cycle after the first rising edge following reset release.
  - After a branch edge, out_valid = 0 for exactly one cycle; the target instruction is at the head in the following cycle.
- Back-to-back branches: each one re-flushes; the last target wins.
- Ordering: instructions leave strictly in fetch order; none is duplicated or lost except by flush.

Optional Feature:
- Macro: FETCH_STATS_EN.
- Defined:
  - fetch_count increments on every push.
  - flush_count increments once per branch edge by the number of entries discarded (count before the flush).
  - Both wrap modulo 2^32 and reset to 0.
- Undefined: both ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then release with out_ready = 1 and the memory model returning inst_data = addr ^ 32'hA5A5_0000 -> first output cycle out_inst = 32'hA5A5_0000, out_pc = 4; following cycles give out_pc 8, 12, 16 each cycle.
- out_ready = 0 for 6 cycles after reset -> count saturates at 4 and inst_addr holds at 16; with out_ready = 1 thereafter -> heads with out_pc 4, 8, 12, 16, 20 in consecutive cycles, no gaps.
- Full FIFO with out_ready = 1 in the same cycle -> a simultaneous push and pop occurs, count stays 4 and inst_addr advances by 4.
- With 3 entries buffered, pulse branch_taken with branch_addr = 32'h43 and out_ready = 1 -> next cycle out_valid = 0 and inst_addr = 32'h40; the cycle after, out_pc = 32'h44 and out_inst = 32'h40 ^ 32'hA5A5_0000.
- Assert rst asynchronously between edges while the FIFO holds 2 entries -> out_valid drops to 0 and inst_addr = RESET_PC without waiting for a clock edge.
- With FETCH_STATS_EN defined, fetch 10 words with out_ready = 0 and FIFO_DEPTH = 4, then branch -> fetch_count = 4 and flush_count = 4.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: drives the fetch address, buffers returned words with PC+4 in a
// prefetch FIFO and hands them to ID over valid/ready. Optional statistics via FETCH_STATS_EN.
module if_fetch_unit #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] flush_count
`endif
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(FIFO_DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]   count_q, count_d;

  logic [31:0] inst_mem [FIFO_DEPTH];
  logic [31:0] pc_mem   [FIFO_DEPTH];

  logic full;
  logic pop;
  logic push;

  assign full      = (count_q == DepthCnt);
  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready & ~branch_taken;
  // A full FIFO still accepts a word when its head leaves in the same cycle.
  assign push      = ~branch_taken & (~full | pop);
  assign inst_addr = fetch_pc_q;

  always_comb begin
    out_inst = '0;
    out_pc   = '0;
    if (out_valid) begin
      out_inst = inst_mem[rd_ptr_q];
      out_pc   = pc_mem[rd_ptr_q];
    end
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (branch_taken) begin
      fetch_pc_d = {branch_addr[31:2], 2'b00};
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        wr_ptr_d   = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + (PtrW + 1)'(1);
      end else if (pop && !push) begin
        count_d = count_q - (PtrW + 1)'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: out_inst/out_pc are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr_q] <= inst_data;
      pc_mem[wr_ptr_q]   <= fetch_pc_q + 32'd4;
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count_q;
  logic [31:0] flush_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      if (push) begin
        fetch_count_q <= fetch_count_q + 32'd1;
      end
      if (branch_taken) begin
        flush_count_q <= flush_count_q + 32'(count_q);
      end
    end
  end

  assign fetch_count = fetch_count_q;
  assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit; statistics checks run when FETCH_STATS_EN
// is defined.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        branch_taken;
  logic [31:0] branch_addr;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count;
  logic [31:0] flush_count;
`endif

  int checks = 0;
  int errors = 0;

  if_fetch_unit #(
    .FIFO_DEPTH (4),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_addr    (inst_addr),
    .inst_data    (inst_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_inst     (out_inst),
    .out_pc       (out_pc),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr)
`ifdef FETCH_STATS_EN
    ,
    .fetch_count  (fetch_count),
    .flush_count  (flush_count)
`endif
  );

  // Combinational instruction memory model.
  assign inst_data = inst_addr ^ 32'hA5A5_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    out_ready    = 1'b0;
    branch_taken = 1'b0;
    branch_addr  = 32'h0;

    // Reset state
    step();
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_inst", out_inst, 32'h0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_addr", inst_addr, 32'h0);

    // Streaming with out_ready held high
    rst       = 1'b0;
    out_ready = 1'b1;
    step();
    check("s_valid", {31'b0, out_valid}, 32'd1);
    check("s_inst0", out_inst, 32'hA5A5_0000);
    check("s_pc0", out_pc, 32'd4);
    step();
    check("s_pc1", out_pc, 32'd8);
    step();
    check("s_pc2", out_pc, 32'd12);
    check("s_inst2", out_inst, 32'hA5A5_0008);
    step();
    check("s_pc3", out_pc, 32'd16);

    // Stall fills the FIFO, then drain with simultaneous push/pop
    out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) step();
    check("full_addr", inst_addr, 32'd16);
    check("full_head", out_pc, 32'd4);
    out_ready = 1'b1;
    step();
    check("pp_addr", inst_addr, 32'd20);
    check("d_pc8", out_pc, 32'd8);
    step();
    check("d_pc12", out_pc, 32'd12);
    step();
    check("d_pc16", out_pc, 32'd16);
    step();
    check("d_pc20", out_pc, 32'd20);
    check("d_inst20", out_inst, 32'hA5A5_0010);
    check("d_valid", {31'b0, out_valid}, 32'd1);

    // Branch with three entries buffered
    out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) step();
    check("b_pre_addr", inst_addr, 32'd12);
    out_ready    = 1'b1;
    branch_taken = 1'b1;
    branch_addr  = 32'h43;
    step();
    branch_taken = 1'b0;
    check("b_valid0", {31'b0, out_valid}, 32'd0);
    check("b_addr", inst_addr, 32'h40);
    check("b_inst0", out_inst, 32'h0);
    step();
    check("b_valid1", {31'b0, out_valid}, 32'd1);
    check("b_pc", out_pc, 32'h44);
    check("b_inst", out_inst, 32'hA5A5_0040);

    // Back-to-back branches: last target wins
    branch_taken = 1'b1;
    branch_addr  = 32'h100;
    step();
    branch_addr  = 32'h203;
    step();
    branch_taken = 1'b0;
    check("bb_valid", {31'b0, out_valid}, 32'd0);
    check("bb_addr", inst_addr, 32'h200);
    step();
    check("bb_pc", out_pc, 32'h204);

    // Fetch address wraps at 2^32
    out_ready    = 1'b0;
    branch_taken = 1'b1;
    branch_addr  = 32'hFFFF_FFFE;
    step();
    branch_taken = 1'b0;
    check("w_addr", inst_addr, 32'hFFFF_FFFC);
    step();
    check("w_pc", out_pc, 32'h0);
    check("w_inst", out_inst, 32'h5A5A_FFFC);
    check("w_addr2", inst_addr, 32'h0);

    // Asynchronous reset between edges with two entries held
    do_reset();
    step();
    step();
    check("ar_pre_valid", {31'b0, out_valid}, 32'd1);
    check("ar_pre_addr", inst_addr, 32'd8);
    #2;
    rst = 1'b1;
    #1;
    check("ar_valid", {31'b0, out_valid}, 32'd0);
    check("ar_addr", inst_addr, 32'h0);
    check("ar_pc", out_pc, 32'h0);
    step();
    rst = 1'b0;

`ifdef FETCH_STATS_EN
    check("st_rst_fetch", fetch_count, 32'd0);
    check("st_rst_flush", flush_count, 32'd0);
    for (int i = 0; i < 10; i++) step();
    branch_taken = 1'b1;
    branch_addr  = 32'h80;
    step();
    branch_taken = 1'b0;
    check("st_fetch", fetch_count, 32'd4);
    check("st_flush", flush_count, 32'd4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
